mulu_x2y2_tester: RTL and testbench



---
 rtl/mulu_x2y2_tester_pkg.sv | 33 +++
 rtl/mulu_x2y2_tester_if.sv | 18 +
 rtl/mulu_x2y2_tester.sv | 143 ++++++++++++++
 tb/tb_mulu_x2y2_tester.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/mulu_x2y2_tester_pkg.sv
// Shared definitions for the 2x2 unsigned multiplier tester.
//   - Operand/product widths of the multiplier pin interface.
//   - Tester FSM state encoding (3-bit, IDLE=0 .. DONE=4).
//   - Golden product helper used when checking each vector.
package mulu_x2y2_tester_pkg;

  localparam int X_WIDTH   = 2;
  localparam int Y_WIDTH   = 2;
  localparam int P_WIDTH   = 4;
  localparam int IDX_WIDTH = X_WIDTH + Y_WIDTH;  // one vector per operand pair
  localparam int CNT_WIDTH = 4;                  // shared settle/timeout counter
  localparam int ERR_WIDTH = 5;                  // 0..16 mismatches

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_DRIVE = 3'd1,
    ST_WAIT  = 3'd2,
    ST_CHECK = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  function automatic logic [P_WIDTH-1:0] golden_product(
    input logic [X_WIDTH-1:0] x,
    input logic [Y_WIDTH-1:0] y
  );
    logic [P_WIDTH-1:0] xe;
    logic [P_WIDTH-1:0] ye;
    xe = P_WIDTH'(x);
    ye = P_WIDTH'(y);
    return xe * ye;
  endfunction

endpackage

// File: rtl/mulu_x2y2_tester_if.sv
// Pin interface between the tester (initiator) and a 2x2 unsigned multiplier.
//   x_o, y_o : operands driven by the tester
//   p_i      : product returned by the multiplier
//   rdy_i    : result-valid from the multiplier (only used when the tester
//              is built with USE_READY=1)
// master = tester side, slave = multiplier side.
interface mulu_x2y2_tester_if;
  import mulu_x2y2_tester_pkg::*;

  logic [X_WIDTH-1:0] x_o;
  logic [Y_WIDTH-1:0] y_o;
  logic [P_WIDTH-1:0] p_i;
  logic               rdy_i;

  modport master (output x_o, output y_o, input p_i, input rdy_i);
  modport slave  (input x_o, input y_o, output p_i, output rdy_i);

endinterface

// File: rtl/mulu_x2y2_tester.sv
// Self-checking stimulus driver for a 2x2 unsigned multiplier.
// On start it walks all 16 operand pairs (x = idx[3:2], y = idx[1:0]),
// waits SETTLE_CYCLES (and optionally rdy_i, bounded by TIMEOUT), samples
// the product and compares it against the golden product.
//
// Ports:
//   clk        rising-edge clock
//   reset      asynchronous reset, active-low
//   start      one-cycle run request, honoured in IDLE or DONE
//   mul        multiplier pin interface (master side)
//   busy       run in progress (DRIVE/WAIT/CHECK)
//   done       run complete, held until next accepted start or reset
//   pass       done and no mismatches
//   err_count  mismatching vectors in the current run
//   fail_x/y   operands of the first failing vector
//   fail_p     product sampled at the first failure
module mulu_x2y2_tester
  import mulu_x2y2_tester_pkg::*;
#(
  parameter int SETTLE_CYCLES = 2,   // 1..15
  parameter int USE_READY     = 0,
  parameter int TIMEOUT       = 8    // >= SETTLE_CYCLES
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  mulu_x2y2_tester_if.master   mul,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic [ERR_WIDTH-1:0] err_count,
  output logic [X_WIDTH-1:0]   fail_x,
  output logic [Y_WIDTH-1:0]   fail_y,
  output logic [P_WIDTH-1:0]   fail_p
);

  localparam logic [CNT_WIDTH-1:0] SETTLE_LAST  = CNT_WIDTH'(SETTLE_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] TIMEOUT_LAST = CNT_WIDTH'(TIMEOUT - 1);
  localparam logic [IDX_WIDTH-1:0] IDX_LAST     = '1;

  state_t               state;
  state_t               state_nx;
  logic [IDX_WIDTH-1:0] idx;
  logic [CNT_WIDTH-1:0] cnt;
  logic                 tmo_flag;
  logic                 start_run;
  logic                 set_tmo;
  logic                 mismatch;

  // Next-state logic
  always_comb begin
    state_nx  = state;
    start_run = 1'b0;
    set_tmo   = 1'b0;
    case (state)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_nx  = ST_DRIVE;
          start_run = 1'b1;
        end
      end
      ST_DRIVE: state_nx = ST_WAIT;
      ST_WAIT: begin
        if (USE_READY == 0) begin
          if (cnt == SETTLE_LAST) state_nx = ST_CHECK;
        end else begin
          // A valid rdy after settling wins over a coincident timeout.
          if ((cnt >= SETTLE_LAST) && mul.rdy_i) begin
            state_nx = ST_CHECK;
          end else if (cnt == TIMEOUT_LAST) begin
            state_nx = ST_CHECK;
            set_tmo  = 1'b1;
          end
        end
      end
      ST_CHECK: state_nx = (idx == IDX_LAST) ? ST_DONE : ST_DRIVE;
      default:  state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= ST_IDLE;
    else        state <= state_nx;
  end

  // Operands hold the current vector, so they double as the golden inputs.
  assign mismatch = tmo_flag || (mul.p_i != golden_product(mul.x_o, mul.y_o));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      idx       <= '0;
      cnt       <= '0;
      tmo_flag  <= 1'b0;
      mul.x_o   <= '0;
      mul.y_o   <= '0;
      done      <= 1'b0;
      err_count <= '0;
      fail_x    <= '0;
      fail_y    <= '0;
      fail_p    <= '0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          if (start_run) begin
            idx       <= '0;
            done      <= 1'b0;
            err_count <= '0;
            fail_x    <= '0;
            fail_y    <= '0;
            fail_p    <= '0;
          end
        end
        ST_DRIVE: begin
          mul.x_o  <= idx[IDX_WIDTH-1 -: X_WIDTH];
          mul.y_o  <= idx[Y_WIDTH-1:0];
          cnt      <= '0;
          tmo_flag <= 1'b0;
        end
        ST_WAIT: begin
          cnt <= cnt + 1'b1;
          if (set_tmo) tmo_flag <= 1'b1;
        end
        ST_CHECK: begin
          if (mismatch) begin
            err_count <= err_count + 1'b1;
            if (err_count == '0) begin
              fail_x <= mul.x_o;
              fail_y <= mul.y_o;
              fail_p <= mul.p_i;
            end
          end
          if (idx == IDX_LAST) done <= 1'b1;
          else                 idx  <= idx + 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign busy = (state == ST_DRIVE) || (state == ST_WAIT) || (state == ST_CHECK);
  assign pass = done && (err_count == '0);

endmodule

// File: tb/tb_mulu_x2y2_tester.sv
module tb_mulu_x2y2_tester;
  import mulu_x2y2_tester_pkg::*;

  typedef struct {
    logic [4:0] err;
    logic [1:0] fx;
    logic [1:0] fy;
    logic [3:0] fp;
    logic       pass;
    int         lat;
    int         st;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic start0 = 1'b0;
  logic start1 = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad = 0;
  int fault = 0;

  exp_t q0[$];
  exp_t q1[$];

  mulu_x2y2_tester_if mif0();
  mulu_x2y2_tester_if mif1();

  logic       busy0, done0, pass0, busy1, done1, pass1;
  logic [4:0] err0, err1;
  logic [1:0] fx0, fy0, fx1, fy1;
  logic [3:0] fp0, fp1;

  // Behavioural multiplier with injectable faults:
  // 0 = correct, 1 = p[0] stuck at 0, 2 = p stuck at 4'hF.
  function automatic logic [3:0] mul_model(input logic [1:0] a, input logic [1:0] b, input int f);
    logic [3:0] p;
    p = {2'b00, a} * {2'b00, b};
    if (f == 1) p[0] = 1'b0;
    else if (f == 2) p = 4'hF;
    return p;
  endfunction

  assign mif0.p_i   = mul_model(mif0.x_o, mif0.y_o, fault);
  assign mif0.rdy_i = 1'b1;
  assign mif1.p_i   = mul_model(mif1.x_o, mif1.y_o, 0);
  assign mif1.rdy_i = 1'b0;

  mulu_x2y2_tester dut0 (
    .clk(clk), .reset(reset), .start(start0), .mul(mif0),
    .busy(busy0), .done(done0), .pass(pass0), .err_count(err0),
    .fail_x(fx0), .fail_y(fy0), .fail_p(fp0)
  );

  mulu_x2y2_tester #(.SETTLE_CYCLES(2), .USE_READY(1), .TIMEOUT(8)) dut1 (
    .clk(clk), .reset(reset), .start(start1), .mul(mif1),
    .busy(busy1), .done(done1), .pass(pass1), .err_count(err1),
    .fail_x(fx1), .fail_y(fy1), .fail_p(fp1)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Scoreboard monitors: compare on each rising edge of done.
  logic done0_q = 1'b0;
  logic done1_q = 1'b0;
  always @(negedge clk) begin
    if (done0 && !done0_q) begin
      if (q0.size() == 0) begin
        total++; bad++;
        $display("FAIL dut0_unexpected_done: got done=1 expected no result pending");
      end else begin
        exp_t e;
        e = q0.pop_front();
        chk("dut0_err_count", err0, e.err);
        chk("dut0_fail_x", fx0, e.fx);
        chk("dut0_fail_y", fy0, e.fy);
        chk("dut0_fail_p", fp0, e.fp);
        chk("dut0_pass", pass0, e.pass);
        chk("dut0_latency", cyc - e.st, e.lat);
      end
    end
    done0_q <= done0;
  end

  always @(negedge clk) begin
    if (done1 && !done1_q) begin
      if (q1.size() == 0) begin
        total++; bad++;
        $display("FAIL dut1_unexpected_done: got done=1 expected no result pending");
      end else begin
        exp_t e;
        e = q1.pop_front();
        chk("dut1_err_count", err1, e.err);
        chk("dut1_fail_x", fx1, e.fx);
        chk("dut1_fail_y", fy1, e.fy);
        chk("dut1_fail_p", fp1, e.fp);
        chk("dut1_pass", pass1, e.pass);
        chk("dut1_latency", cyc - e.st, e.lat);
      end
    end
    done1_q <= done1;
  end

  // Pulse start for one edge and push the expected result.
  task automatic issue(input int which, input logic [4:0] err, input logic [1:0] fx,
                       input logic [1:0] fy, input logic [3:0] fp, input logic ps,
                       input int lat, output int st);
    exp_t e;
    @(negedge clk);
    if (which == 0) start0 = 1'b1; else start1 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    start1 = 1'b0;
    st = cyc;
    e.err = err; e.fx = fx; e.fy = fy; e.fp = fp; e.pass = ps; e.lat = lat; e.st = st;
    if (which == 0) q0.push_back(e); else q1.push_back(e);
  endtask

  task automatic wait_done(input int which, input int budget);
    int n;
    n = 0;
    while ((((which == 0) ? done0 : done1) !== 1'b1) && (n < budget)) begin
      @(negedge clk);
      n++;
    end
    chk((which == 0) ? "dut0_done_within_budget" : "dut1_done_within_budget", (n < budget), 1);
  endtask

  initial begin
    int st;
    // Reset state
    #1;
    chk("rst_busy", busy0, 0);
    chk("rst_done", done0, 0);
    chk("rst_pass", pass0, 0);
    chk("rst_err", err0, 0);
    chk("rst_fail_x", fx0, 0);
    chk("rst_fail_y", fy0, 0);
    chk("rst_fail_p", fp0, 0);
    chk("rst_x", mif0.x_o, 0);
    chk("rst_y", mif0.y_o, 0);
    chk("rst_busy1", busy1, 0);
    repeat (3) @(negedge clk);
    reset = 1'b1;

    // Correct multiplier, default parameters
    fault = 0;
    issue(0, 5'd0, 2'd0, 2'd0, 4'd0, 1'b1, 64, st);
    chk("busy_after_start", busy0, 1);
    wait_done(0, 100);
    chk("done_x_hold", mif0.x_o, 3);
    chk("done_y_hold", mif0.y_o, 3);
    chk("done_busy", busy0, 0);

    // p[0] stuck at 0
    fault = 1;
    issue(0, 5'd4, 2'd1, 2'd1, 4'd0, 1'b0, 64, st);
    wait_done(0, 100);

    // p stuck at 4'hF
    fault = 2;
    issue(0, 5'd16, 2'd0, 2'd0, 4'd15, 1'b0, 64, st);
    wait_done(0, 100);

    // Restart from DONE clears results; mid-run start and start at the
    // DONE transition are ignored.
    fault = 0;
    issue(0, 5'd0, 2'd0, 2'd0, 4'd0, 1'b1, 64, st);
    chk("restart_done_clear", done0, 0);
    chk("restart_err_clear", err0, 0);
    chk("restart_fail_p_clear", fp0, 0);
    chk("restart_busy", busy0, 1);
    repeat (20) @(negedge clk);
    start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    while (cyc < st + 63) @(negedge clk);
    start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    chk("done_at_last_check_edge", done0, 1);
    @(negedge clk);
    chk("start_at_done_edge_busy", busy0, 0);
    chk("start_at_done_edge_done", done0, 1);

    // Asynchronous reset during vector 5
    fault = 2;
    @(negedge clk);
    start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    repeat (21) @(negedge clk);
    chk("mid_run_busy", busy0, 1);
    chk("mid_run_x", mif0.x_o, 1);
    chk("mid_run_y", mif0.y_o, 1);
    chk("mid_run_err", err0, 5);
    #2 reset = 1'b0;
    #1;
    chk("async_rst_busy", busy0, 0);
    chk("async_rst_x", mif0.x_o, 0);
    chk("async_rst_y", mif0.y_o, 0);
    chk("async_rst_err", err0, 0);
    @(negedge clk);
    reset = 1'b1;
    fault = 0;
    issue(0, 5'd0, 2'd0, 2'd0, 4'd0, 1'b1, 64, st);
    wait_done(0, 100);

    // USE_READY=1 with rdy held low: every vector times out
    issue(1, 5'd16, 2'd0, 2'd0, 4'd0, 1'b0, 160, st);
    wait_done(1, 200);
    @(negedge clk);

    chk("scoreboard0_drained", q0.size(), 0);
    chk("scoreboard1_drained", q1.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish expected finish before time limit");
    $fatal(1);
  end

endmodule
